// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: store size encodings, dump FSM states and byte-lane enables
// shared by the MEM stage and its data memory.
package mem_stage_pkg;

   localparam int LANES = 4;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      DUMP_IDLE = 2'b00,
      DUMP_SEND = 2'b01,
      DUMP_DONE = 2'b10
   } dump_state_t;

   // Codes 10 and 11 both mean a full-word store.
   function automatic logic [LANES-1:0] lane_en(input logic [1:0] size, input logic [1:0] off);
      return size == SIZE_BYTE ? 4'b0001 << off :
             size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: one synchronous byte-enable write port, two asynchronous read ports.
// Reads during a write to the same word return the old contents.
module data_memory #(
   parameter int BITS_SIZE     = 32,
   parameter int MEM_ADDR_BITS = 8
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [BITS_SIZE/8-1:0]   i_be,
   input  logic [MEM_ADDR_BITS-1:0] i_waddr,
   input  logic [BITS_SIZE-1:0]     i_wdata,
   input  logic [MEM_ADDR_BITS-1:0] i_raddr_a,
   output logic [BITS_SIZE-1:0]     o_rdata_a,
   input  logic [MEM_ADDR_BITS-1:0] i_raddr_b,
   output logic [BITS_SIZE-1:0]     o_rdata_b
);
   logic [BITS_SIZE-1:0] mem [2**MEM_ADDR_BITS] = '{default: '0};

   always_ff @(posedge i_clk)
      if (i_we)
         for (int b = 0; b < BITS_SIZE/8; b++)
            if (i_be[b]) mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];

   assign o_rdata_a = mem[i_raddr_a];
   assign o_rdata_b = mem[i_raddr_b];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data memory access, BEQ/BNE resolution and a valid/ready memory dump engine.
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses and suppress misaligned stores.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int BITS_SIZE     = 32,
   parameter int MEM_ADDR_BITS = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_step,
   input  logic [BITS_SIZE-1:0]     i_alu,
   input  logic [BITS_SIZE-1:0]     i_register_2,
   input  logic                     i_zero,
   input  logic                     i_branch,
   input  logic                     i_new_branch,
   input  logic                     i_mem_write,
   input  logic                     i_mem_read,
   input  logic [1:0]               i_size_filter,
   output logic [BITS_SIZE-1:0]     o_read_data,
   output logic                     o_pc_src,
   output logic                     o_misaligned,
   input  logic                     i_dump_start,
   input  logic                     i_dump_ready,
   output logic                     o_dump_valid,
   output logic [MEM_ADDR_BITS-1:0] o_dump_addr,
   output logic [BITS_SIZE-1:0]     o_dump_data,
   output logic                     o_dump_done
);
   logic [MEM_ADDR_BITS-1:0] idx;
   logic [LANES-1:0]         be;
   logic [BITS_SIZE-1:0]     wdata;
   logic                     we;
   logic                     unused_bits;
   dump_state_t              state;

   // Upper address bits are dropped so addresses wrap around the memory.
   assign idx         = i_alu[MEM_ADDR_BITS+1:2];
   assign be          = lane_en(i_size_filter, i_alu[1:0]);
   assign wdata       = i_size_filter == SIZE_BYTE ? {(BITS_SIZE/8){i_register_2[7:0]}} :
                        i_size_filter == SIZE_HALF ? {(BITS_SIZE/16){i_register_2[15:0]}} : i_register_2;
   assign o_pc_src    = (i_branch & i_zero) | (i_new_branch & ~i_zero);
   assign unused_bits = ^{i_mem_read, i_alu[BITS_SIZE-1:MEM_ADDR_BITS+2]};

`ifdef MEM_ALIGN_CHECK_EN
   logic mis_acc;
   assign mis_acc = i_size_filter == SIZE_HALF ? i_alu[0] :
                    i_size_filter != SIZE_BYTE ? |i_alu[1:0] : 1'b0;
   assign we      = i_step & i_mem_write & ~i_reset & ~mis_acc;
   always_ff @(posedge i_clk)
      if (i_reset) o_misaligned <= 1'b0;
      else if (i_step & (i_mem_write | i_mem_read) & mis_acc) o_misaligned <= 1'b1;
`else
   assign we           = i_step & i_mem_write & ~i_reset;
   assign o_misaligned = 1'b0;
`endif

   data_memory #(
      .BITS_SIZE     (BITS_SIZE),
      .MEM_ADDR_BITS (MEM_ADDR_BITS)
   ) u_mem (
      .i_clk     (i_clk),
      .i_we      (we),
      .i_be      (be),
      .i_waddr   (idx),
      .i_wdata   (wdata),
      .i_raddr_a (idx),
      .o_rdata_a (o_read_data),
      .i_raddr_b (o_dump_addr),
      .o_rdata_b (o_dump_data)
   );

   always_ff @(posedge i_clk)
      if (i_reset) begin
         state        <= DUMP_IDLE;
         o_dump_valid <= 1'b0;
         o_dump_addr  <= '0;
         o_dump_done  <= 1'b0;
      end else
         case (state)
            DUMP_IDLE:
               if (i_dump_start) begin
                  state        <= DUMP_SEND;
                  o_dump_valid <= 1'b1;
                  o_dump_addr  <= '0;
               end
            DUMP_SEND:
               if (i_dump_ready)
                  if (&o_dump_addr) begin
                     state        <= DUMP_DONE;
                     o_dump_valid <= 1'b0;
                     o_dump_done  <= 1'b1;
                  end else
                     o_dump_addr <= o_dump_addr + 1'b1;
            default: begin
               state       <= DUMP_IDLE;
               o_dump_done <= 1'b0;
            end
         endcase
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus feeding a scoreboard; a negedge monitor pops and compares
// expected pipeline outputs and every accepted dump word.
module tb_mem_stage;
   logic        i_clk = 1'b0, i_reset = 1'b1, i_step = 1'b0;
   logic [31:0] i_alu = '0, i_register_2 = '0;
   logic        i_zero = 1'b0, i_branch = 1'b0, i_new_branch = 1'b0;
   logic        i_mem_write = 1'b0, i_mem_read = 1'b0;
   logic [1:0]  i_size_filter = 2'b10;
   logic        i_dump_start = 1'b0, i_dump_ready = 1'b0;
   logic [31:0] o_read_data, o_dump_data;
   logic        o_pc_src, o_misaligned, o_dump_valid, o_dump_done;
   logic [7:0]  o_dump_addr;

   mem_stage dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_alu(i_alu),
      .i_register_2(i_register_2), .i_zero(i_zero), .i_branch(i_branch),
      .i_new_branch(i_new_branch), .i_mem_write(i_mem_write), .i_mem_read(i_mem_read),
      .i_size_filter(i_size_filter), .o_read_data(o_read_data), .o_pc_src(o_pc_src),
      .o_misaligned(o_misaligned), .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
      .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
      .o_dump_done(o_dump_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {string name; int kind; logic [31:0] exp; int cyc;} item_t;
   typedef struct {logic [7:0] a; logic [31:0] d;} dump_t;
   item_t       sb[$];
   dump_t       dq[$];
   item_t       it;
   dump_t       dw;
   logic [31:0] mm [256];
   int cyc = 0, tests = 0, fails = 0, acc_cnt = 0, done_cnt = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   function automatic logic [31:0] act(input int k);
      return k == 0 ? o_read_data : k == 1 ? {31'b0, o_pc_src} : k == 2 ? {31'b0, o_misaligned} :
             k == 3 ? {31'b0, o_dump_valid} : k == 4 ? {24'b0, o_dump_addr} : {31'b0, o_dump_done};
   endfunction

   task automatic expect_now(input string n, input int k, input logic [31:0] e);
      sb.push_back('{n, k, e, cyc});
   endtask

   task automatic push_dump();
      for (int a = 0; a < 256; a++) dq.push_back('{a[7:0], mm[a]});
   endtask

   always @(negedge i_clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         it = sb.pop_front();
         check(it.name, act(it.kind), it.exp);
      end
      if (o_dump_valid && i_dump_ready) begin
         acc_cnt++;
         if (dq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dump_extra: got addr %h expected no word", o_dump_addr);
         end else begin
            dw = dq.pop_front();
            check("dump_addr", {24'b0, o_dump_addr}, {24'b0, dw.a});
            check("dump_data", o_dump_data, dw.d);
         end
      end
      if (o_dump_done) done_cnt++;
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int n;
      for (int a = 0; a < 256; a++) mm[a] = '0;
      step();
      step();
      expect_now("rst_valid", 3, 0);
      expect_now("rst_addr", 4, 0);
      expect_now("rst_done", 5, 0);
      expect_now("rst_mis", 2, 0);
      step();
      i_reset = 1'b0;
      i_step  = 1'b1;
      // word store, old data visible during the write cycle
      i_alu = 32'h10; i_register_2 = 32'hDEADBEEF; i_size_filter = 2'b10; i_mem_write = 1'b1;
      expect_now("rdw_old", 0, 32'h0);
      step();
      i_mem_write = 1'b0;
      expect_now("rd_word", 0, 32'hDEADBEEF);
      step();
      i_alu = 32'h13; i_register_2 = 32'h000000AA; i_size_filter = 2'b00; i_mem_write = 1'b1;
      expect_now("rdw_old2", 0, 32'hDEADBEEF);
      step();
      i_mem_write = 1'b0;
      expect_now("rd_byte", 0, 32'hAAADBEEF);
      step();
      i_step = 1'b0; i_alu = 32'h11; i_register_2 = 32'h55; i_mem_write = 1'b1;
      step();
      i_mem_write = 1'b0; i_step = 1'b1; i_alu = 32'h10;
      expect_now("rd_nostep", 0, 32'hAAADBEEF);
      step();
      i_alu = 32'h22; i_register_2 = 32'h1234BEEF; i_size_filter = 2'b01; i_mem_write = 1'b1;
      step();
      i_mem_write = 1'b0; i_alu = 32'h422;
      expect_now("rd_half_wrap", 0, 32'hBEEF0000);
      mm[4] = 32'hAAADBEEF;
      mm[8] = 32'hBEEF0000;
      step();
      i_branch = 1'b1; i_zero = 1'b1;
      expect_now("beq_taken", 1, 1);
      step();
      i_branch = 1'b0; i_new_branch = 1'b1;
      expect_now("bne_not", 1, 0);
      step();
      i_zero = 1'b0;
      expect_now("bne_taken", 1, 1);
      step();
      i_branch = 1'b1; i_new_branch = 1'b0;
      expect_now("beq_not", 1, 0);
      step();
      i_branch = 1'b0;
      // full dump, ready toggling, second start mid-dump
      push_dump();
      i_dump_start = 1'b1;
      step();
      i_dump_start = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 2000) begin
         i_dump_ready = ~i_dump_ready;
         i_dump_start = (n == 100);
         step();
         n++;
      end
      i_dump_ready = 1'b0; i_dump_start = 1'b0;
      repeat (5) step();
      check("dump1_count", acc_cnt, 256);
      check("dump1_done", done_cnt, 1);
      check("dump1_left", dq.size(), 0);
      // reset mid-dump at address 5
      acc_cnt = 0;
      push_dump();
      i_dump_ready = 1'b1; i_dump_start = 1'b1;
      step();
      i_dump_start = 1'b0;
      n = 0;
      while (!(o_dump_valid && o_dump_addr == 8'd5) && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check("addr5_reached", {24'b0, o_dump_addr}, 5);
      step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      dq.delete();
      expect_now("abort_valid", 3, 0);
      expect_now("abort_addr", 4, 0);
      repeat (4) step();
      check("abort_no_done", done_cnt, 1);
      acc_cnt = 0;
      push_dump();
      i_dump_start = 1'b1;
      step();
      i_dump_start = 1'b0;
      n = 0;
      while (done_cnt < 2 && n < 600) begin
         step();
         n++;
      end
      i_dump_ready = 1'b0;
      repeat (3) step();
      check("dump2_count", acc_cnt, 256);
      check("dump2_done", done_cnt, 2);
      // misaligned word store at 0x12
      i_alu = 32'h12; i_register_2 = 32'h12345678; i_size_filter = 2'b10; i_mem_write = 1'b1;
      step();
      i_mem_write = 1'b0; i_alu = 32'h10;
`ifdef MEM_ALIGN_CHECK_EN
      expect_now("mis_rd", 0, 32'hAAADBEEF);
      expect_now("mis_set", 2, 1);
      step();
      step();
      expect_now("mis_sticky", 2, 1);
      step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      expect_now("mis_cleared", 2, 0);
`else
      expect_now("mis_rd", 0, 32'h12345678);
      expect_now("mis_off", 2, 0);
`endif
      step();
      @(negedge i_clk);
      @(negedge i_clk);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
